// File: rtl/spi_responder.sv
`timescale 1ns/1ps
// spi_responder: SPI mode-0 target giving an initiator byte-wide access to a
// register bank. SCLK/NCS/MOSI are oversampled in the clk domain.
// Transaction: command byte, address byte, then data bytes with the address
// auto-incrementing (8-bit wrap).
module spi_responder #(
    parameter logic [7:0] CMD_WRITE = 8'h0A,
    parameter logic [7:0] CMD_READ  = 8'h0B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       ncs_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       cmd_error
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_W, ADDR_R, WDATA, RDATA, IGNORE
    } state_t;

    state_t      state_reg, state_next;

    // [0],[1] form the synchroniser; [2] is the edge-detect history flop.
    logic [2:0]  sclk_sync_reg;
    logic [2:0]  ncs_sync_reg;
    logic [1:0]  mosi_sync_reg;

    logic [2:0]  bit_cnt_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  tx_shift_reg;
    logic        miso_reg;
    logic [7:0]  reg_addr_reg;
    logic [7:0]  reg_wdata_reg;
    logic        reg_we_reg;
    logic        reg_re_reg;
    logic        rd_pend_reg;
    logic        cmd_error_reg;

    logic        sclk_rise, sclk_fall, ncs_rise, ncs_s, mosi_s;
    logic        byte_done;
    logic [7:0]  rx_byte;

    // Bring the SPI pins into the clk domain; idle levels are sclk=0, ncs=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= 3'b000;
            ncs_sync_reg  <= 3'b111;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk_i};
            ncs_sync_reg  <= {ncs_sync_reg[1:0], ncs_i};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi_i};
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign ncs_rise  = ncs_sync_reg[1] & ~ncs_sync_reg[2];
    assign ncs_s     = ncs_sync_reg[1];
    assign mosi_s    = mosi_sync_reg[1];

    // The byte being completed includes the bit sampled on this very edge.
    assign rx_byte   = {rx_shift_reg[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7) &&
                       (state_reg != IDLE) && !ncs_rise;

    // Receive shifter and bit counter; a partial byte is dropped on ncs_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else if (ncs_rise || state_reg == IDLE) begin
            bit_cnt_reg  <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            rx_shift_reg <= rx_byte;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; chip-select release wins over everything.
    always_comb begin
        state_next = state_reg;
        if (ncs_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:   if (!ncs_s) state_next = CMD;
                CMD:    if (byte_done) begin
                            if (rx_byte == CMD_WRITE)     state_next = ADDR_W;
                            else if (rx_byte == CMD_READ) state_next = ADDR_R;
                            else                          state_next = IGNORE;
                        end
                ADDR_W: if (byte_done) state_next = WDATA;
                ADDR_R: if (byte_done) state_next = RDATA;
                default: state_next = state_reg;
            endcase
        end
    end

    // Register-port strobes, address tracking and command error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_addr_reg  <= 8'h00;
            reg_wdata_reg <= 8'h00;
            reg_we_reg    <= 1'b0;
            reg_re_reg    <= 1'b0;
            rd_pend_reg   <= 1'b0;
            cmd_error_reg <= 1'b0;
        end else begin
            reg_we_reg    <= 1'b0;
            reg_re_reg    <= 1'b0;
            cmd_error_reg <= 1'b0;
            rd_pend_reg   <= reg_re_reg;
            // Address advances the cycle after a write strobe so the strobe
            // itself sees a stable address.
            if (reg_we_reg) begin
                reg_addr_reg <= reg_addr_reg + 8'd1;
            end
            if (byte_done) begin
                case (state_reg)
                    CMD: begin
                        if (rx_byte != CMD_WRITE && rx_byte != CMD_READ) begin
                            cmd_error_reg <= 1'b1;
                        end
                    end
                    ADDR_W: reg_addr_reg <= rx_byte;
                    ADDR_R: begin
                        reg_addr_reg <= rx_byte;
                        reg_re_reg   <= 1'b1;
                    end
                    WDATA: begin
                        reg_wdata_reg <= rx_byte;
                        reg_we_reg    <= 1'b1;
                    end
                    RDATA: begin
                        reg_addr_reg <= reg_addr_reg + 8'd1;
                        reg_re_reg   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Transmit path: load read data one clk after the read strobe, shift on
    // sclk falls while in RDATA, otherwise hold MISO low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_reg <= 8'h00;
            miso_reg     <= 1'b0;
        end else begin
            if (rd_pend_reg) begin
                tx_shift_reg <= reg_rdata;
            end else if (sclk_fall && state_reg == RDATA && !ncs_rise) begin
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
            if (ncs_rise || state_reg != RDATA) begin
                miso_reg <= 1'b0;
            end else if (sclk_fall) begin
                miso_reg <= tx_shift_reg[7];
            end
        end
    end

    assign miso_o    = miso_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_we    = reg_we_reg;
    assign reg_re    = reg_re_reg;
    assign cmd_error = cmd_error_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_responder.sv
`timescale 1ns/1ps
// Directed bench for spi_responder: bit-banged SPI initiator, a register-file
// read model (rdata = addr ^ A5) and negedge monitors logging strobes.
module tb_spi_responder;

    localparam int H = 8;   // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso_o;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       cmd_error;

    int checks = 0;
    int failures = 0;

    int we_cnt = 0, re_cnt = 0, err_cnt = 0, miso_hi_cnt = 0, both_cnt = 0;
    logic [7:0] we_addr [64];
    logic [7:0] we_data [64];
    logic [7:0] re_addr [64];

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [7:0] dummy;
    int we_base, re_base, err_base, hi_base;

    spi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_i    (sclk),
        .ncs_i     (ncs),
        .mosi_i    (mosi),
        .miso_o    (miso_o),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .cmd_error (cmd_error)
    );

    always #5 clk = ~clk;

    // Register file read model: data valid one clk after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= reg_addr ^ 8'hA5;
    end

    // Strobe/level monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_we) begin
            we_addr[we_cnt & 63] = reg_addr;
            we_data[we_cnt & 63] = reg_wdata;
            we_cnt++;
        end
        if (reg_re) begin
            re_addr[re_cnt & 63] = reg_addr;
            re_cnt++;
        end
        if (cmd_error) err_cnt++;
        if (miso_o) miso_hi_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 initiator: drive MOSI while SCLK low, sample MISO while high.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            r = {r[6:0], miso_o};
            sclk = 1'b0;
        end
    endtask

    task automatic run_xfer(input int n);
        ncs = 1'b0;
        wait_clk(8);
        for (int k = 0; k < n; k++) send_bits(tx_buf[k], 8, rx_buf[k]);
        wait_clk(8);
        ncs = 1'b1;
        wait_clk(12);
    endtask

    task automatic mark();
        we_base = we_cnt; re_base = re_cnt; err_base = err_cnt; hi_base = miso_hi_cnt;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, {31'd0, miso_o}, 32'd0);
        chk({tag, "_addr"}, {24'd0, reg_addr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, reg_wdata}, 32'd0);
        chk({tag, "_we"}, {31'd0, reg_we}, 32'd0);
        chk({tag, "_re"}, {31'd0, reg_re}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cmderr"}, {31'd0, cmd_error}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        wait_clk(5);
        chk_reset_vals("rst_init");
        rst = 1'b0;
        wait_clk(5);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single write 0A 1F 52
        mark();
        ncs = 1'b0;
        wait_clk(8);
        chk("wr_busy_start", {31'd0, busy}, 32'd1);
        send_bits(8'h0A, 8, dummy);
        send_bits(8'h1F, 8, dummy);
        send_bits(8'h52, 8, dummy);
        wait_clk(8);
        chk("wr_busy_end", {31'd0, busy}, 32'd1);
        ncs = 1'b1;
        wait_clk(2);
        chk("wr_busy_hold", {31'd0, busy}, 32'd1);
        wait_clk(3);
        chk("wr_busy_drop", {31'd0, busy}, 32'd0);
        wait_clk(8);
        chk("wr_we_count", we_cnt - we_base, 32'd1);
        chk("wr_addr", {24'd0, we_addr[we_base & 63]}, 32'h1F);
        chk("wr_data", {24'd0, we_data[we_base & 63]}, 32'h52);
        chk("wr_no_re", re_cnt - re_base, 32'd0);

        // Burst write with address wrap
        mark();
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'hFE; tx_buf[2] = 8'h11;
        tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
        run_xfer(5);
        chk("bw_we_count", we_cnt - we_base, 32'd3);
        chk("bw_addr0", {24'd0, we_addr[(we_base + 0) & 63]}, 32'hFE);
        chk("bw_data0", {24'd0, we_data[(we_base + 0) & 63]}, 32'h11);
        chk("bw_addr1", {24'd0, we_addr[(we_base + 1) & 63]}, 32'hFF);
        chk("bw_data1", {24'd0, we_data[(we_base + 1) & 63]}, 32'h22);
        chk("bw_addr2", {24'd0, we_addr[(we_base + 2) & 63]}, 32'h00);
        chk("bw_data2", {24'd0, we_data[(we_base + 2) & 63]}, 32'h33);
        chk("bw_final_addr", {24'd0, reg_addr}, 32'h01);

        // Read 0B 00 + two dummy bytes
        mark();
        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        run_xfer(4);
        chk("rd_miso_cmd", {24'd0, rx_buf[0]}, 32'h00);
        chk("rd_miso_addr", {24'd0, rx_buf[1]}, 32'h00);
        chk("rd_byte0", {24'd0, rx_buf[2]}, 32'hA5);
        chk("rd_byte1", {24'd0, rx_buf[3]}, 32'hA4);
        chk("rd_re_count", re_cnt - re_base, 32'd3);
        chk("rd_re_addr0", {24'd0, re_addr[(re_base + 0) & 63]}, 32'h00);
        chk("rd_re_addr1", {24'd0, re_addr[(re_base + 1) & 63]}, 32'h01);
        chk("rd_re_addr2", {24'd0, re_addr[(re_base + 2) & 63]}, 32'h02);
        chk("rd_no_we", we_cnt - we_base, 32'd0);

        // Unknown command 3C
        mark();
        tx_buf[0] = 8'h3C; tx_buf[1] = 8'h10; tx_buf[2] = 8'h99;
        run_xfer(3);
        chk("bad_err_count", err_cnt - err_base, 32'd1);
        chk("bad_no_we", we_cnt - we_base, 32'd0);
        chk("bad_no_re", re_cnt - re_base, 32'd0);
        chk("bad_miso_low", miso_hi_cnt - hi_base, 32'd0);

        // Abort mid data byte, then a clean write
        mark();
        ncs = 1'b0;
        wait_clk(8);
        send_bits(8'h0A, 8, dummy);
        send_bits(8'h20, 8, dummy);
        send_bits(8'h5A, 4, dummy);
        wait_clk(8);
        ncs = 1'b1;
        wait_clk(12);
        chk("abort_no_we", we_cnt - we_base, 32'd0);
        chk("abort_addr_kept", {24'd0, reg_addr}, 32'h20);
        mark();
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h21; tx_buf[2] = 8'h77;
        run_xfer(3);
        chk("post_abort_count", we_cnt - we_base, 32'd1);
        chk("post_abort_addr", {24'd0, we_addr[we_base & 63]}, 32'h21);
        chk("post_abort_data", {24'd0, we_data[we_base & 63]}, 32'h77);

        // Reset in the middle of an address byte
        ncs = 1'b0;
        wait_clk(8);
        send_bits(8'h0B, 8, dummy);
        send_bits(8'h3C, 4, dummy);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_addr", {24'd0, reg_addr}, 32'h22);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        wait_clk(3);
        ncs = 1'b1;
        #2 rst = 1'b0;
        wait_clk(10);
        mark();
        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h05; tx_buf[2] = 8'h00;
        run_xfer(3);
        chk("rst_rd_byte", {24'd0, rx_buf[2]}, 32'hA0);
        chk("rst_rd_re_addr", {24'd0, re_addr[re_base & 63]}, 32'h05);
        chk("rst_rd_no_we", we_cnt - we_base, 32'd0);

        chk("we_re_exclusive", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
